// File: rtl/warp_fetch_sched.sv
// Per-warp fetch scheduler: reloads warps from the SIMT stack TOS, then issues READY warps to fetch.
// Define WARP_SCHED_GTO_EN for greedy-then-oldest issue; default is strict round-robin.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CORE
`define SIZE_CORE 32
`endif

module warp_fetch_sched #(
    parameter int NUM_WARP     = 4,
    parameter int NUM_WARP_LOG = 2,
    parameter int SIZE_PC      = `SIZE_PC,
    parameter int SIZE_CORE    = `SIZE_CORE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic [NUM_WARP-1:0]     warpStart_i,
    input  logic                    exitWarp_i,
    input  logic [NUM_WARP_LOG-1:0] exitWarpId_i,
    input  logic                    branchIssue_i,
    input  logic [NUM_WARP_LOG-1:0] branchIssueWarp_i,
    input  logic                    branchResolved_i,
    input  logic [NUM_WARP_LOG-1:0] branchResolvedWarp_i,
    input  logic [SIZE_PC-1:0]      topPC_i,
    input  logic [SIZE_PC-1:0]      topRPC_i,
    input  logic [SIZE_CORE-1:0]    topActiveMask_i,
    input  logic                    pushInStack_stall_i,
    output logic [NUM_WARP_LOG-1:0] issuedWarp_o,
    output logic                    reconv_o,
    output logic                    fetchValid_o,
    output logic [SIZE_PC-1:0]      fetchPC_o,
    output logic [SIZE_CORE-1:0]    fetchMask_o,
    output logic [NUM_WARP_LOG-1:0] fetchWarp_o,
    input  logic                    fetchReady_i,
    output logic [NUM_WARP-1:0]     warpDone_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RELOAD  = 3'd1,
        ST_READY   = 3'd2,
        ST_BLOCKED = 3'd3,
        ST_DONE    = 3'd4
    } warp_state_e;

    logic [NUM_WARP-1:0]           is_reload;
    logic [NUM_WARP-1:0]           is_ready;
    logic [NUM_WARP*SIZE_PC-1:0]   pc_flat;
    logic [NUM_WARP*SIZE_CORE-1:0] mask_flat;

    logic [NUM_WARP_LOG-1:0] rr_q;
    logic [NUM_WARP_LOG-1:0] reload_sel;
    logic [NUM_WARP_LOG-1:0] issue_sel;
    logic                    reload_found;
    logic                    ready_found;
    logic                    slot_avail;
    logic                    do_reload;
    logic                    do_issue;
    logic                    do_reconv;
    logic                    do_fetch;
    logic [SIZE_PC-1:0]      sel_pc;
    logic [SIZE_CORE-1:0]    sel_mask;

    logic                    fetch_valid_q;
    logic [SIZE_PC-1:0]      fetch_pc_q;
    logic [SIZE_CORE-1:0]    fetch_mask_q;
    logic [NUM_WARP_LOG-1:0] fetch_warp_q;

    always_comb begin
        reload_found = |is_reload;
        reload_sel   = '0;
        for (int i = NUM_WARP - 1; i >= 0; i--) begin
            if (is_reload[i]) begin
                reload_sel = NUM_WARP_LOG'(i);
            end
        end
    end

    // With nothing READY the selection falls back to rrPtr, which is what issuedWarp_o must show.
    always_comb begin
        logic [NUM_WARP_LOG-1:0] idx_w;
        idx_w       = '0;
        ready_found = |is_ready;
        issue_sel   = rr_q;
`ifdef WARP_SCHED_GTO_EN
        if (!is_ready[rr_q]) begin
            for (int i = NUM_WARP - 1; i >= 0; i--) begin
                if (is_ready[i]) begin
                    issue_sel = NUM_WARP_LOG'(i);
                end
            end
        end
`else
        for (int k = NUM_WARP; k >= 1; k--) begin
            idx_w = NUM_WARP_LOG'((int'(rr_q) + k) % NUM_WARP);
            if (is_ready[idx_w]) begin
                issue_sel = idx_w;
            end
        end
`endif
    end

    assign slot_avail = !stall_i && !pushInStack_stall_i && (!fetch_valid_q || fetchReady_i);
    assign do_reload  = slot_avail && reload_found;
    assign do_issue   = slot_avail && !reload_found && ready_found;
    assign sel_pc     = pc_flat[int'(issue_sel)*SIZE_PC +: SIZE_PC];
    assign sel_mask   = mask_flat[int'(issue_sel)*SIZE_CORE +: SIZE_CORE];
    assign do_reconv  = do_issue && (sel_pc == topRPC_i);
    assign do_fetch   = do_issue && !do_reconv;

    assign issuedWarp_o = reload_found ? reload_sel : issue_sel;
    assign reconv_o     = do_reconv;

    for (genvar gi = 0; gi < NUM_WARP; gi++) begin : g_warp
        localparam logic [NUM_WARP_LOG-1:0] WID = NUM_WARP_LOG'(gi);

        warp_state_e          state_q;
        warp_state_e          state_d;
        logic [SIZE_PC-1:0]   pc_q;
        logic [SIZE_PC-1:0]   pc_d;
        logic [SIZE_CORE-1:0] mask_q;
        logic [SIZE_CORE-1:0] mask_d;
        logic                 done_q;
        logic                 ev_exit;
        logic                 ev_res;
        logic                 ev_bi;

        assign ev_exit = exitWarp_i && (exitWarpId_i == WID);
        assign ev_res  = branchResolved_i && (branchResolvedWarp_i == WID);
        assign ev_bi   = branchIssue_i && (branchIssueWarp_i == WID);

        // Scheduler action first, then external events override it by priority.
        always_comb begin
            state_d = state_q;
            pc_d    = pc_q;
            mask_d  = mask_q;
            if (do_reload && reload_sel == WID) begin
                state_d = ST_READY;
                pc_d    = topPC_i;
                mask_d  = topActiveMask_i;
            end
            if (do_issue && issue_sel == WID) begin
                if (do_reconv) begin
                    state_d = ST_RELOAD;
                end else begin
                    pc_d = pc_q + SIZE_PC'(1);
                end
            end
            if (ev_exit) begin
                state_d = ST_DONE;
            end else if (ev_res && state_q == ST_BLOCKED) begin
                state_d = ST_RELOAD;
            end else if (ev_bi && state_q == ST_READY) begin
                state_d = ST_BLOCKED;
            end else if (warpStart_i[gi] && state_q == ST_IDLE) begin
                state_d = ST_RELOAD;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                pc_q    <= '0;
                mask_q  <= '0;
                done_q  <= 1'b0;
            end else if (!stall_i) begin
                state_q <= state_d;
                pc_q    <= pc_d;
                mask_q  <= mask_d;
                done_q  <= (state_d == ST_DONE);
            end
        end

        assign is_reload[gi]                        = (state_q == ST_RELOAD);
        assign is_ready[gi]                         = (state_q == ST_READY);
        assign pc_flat[gi*SIZE_PC +: SIZE_PC]       = pc_q;
        assign mask_flat[gi*SIZE_CORE +: SIZE_CORE] = mask_q;
        assign warpDone_o[gi]                       = done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_mask_q  <= '0;
            fetch_warp_q  <= '0;
        end else if (do_fetch) begin
            fetch_valid_q <= 1'b1;
            fetch_pc_q    <= sel_pc;
            fetch_mask_q  <= sel_mask;
            fetch_warp_q  <= issue_sel;
        end else if (!stall_i && fetchReady_i) begin
            fetch_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= NUM_WARP_LOG'(NUM_WARP - 1);
        end else if (do_issue) begin
            rr_q <= issue_sel;
        end
    end

    assign fetchValid_o = fetch_valid_q;
    assign fetchPC_o    = fetch_pc_q;
    assign fetchMask_o  = fetch_mask_q;
    assign fetchWarp_o  = fetch_warp_q;

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Self-checking bench for warp_fetch_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_warp_fetch_sched;

    localparam int NW  = 4;
    localparam int NWL = 2;
    localparam int PCW = 8;
    localparam int CW  = 4;

    localparam int S_IDLE    = 0;
    localparam int S_RELOAD  = 1;
    localparam int S_READY   = 2;
    localparam int S_BLOCKED = 3;
    localparam int S_DONE    = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           stall_i;
    logic [NW-1:0]  warpStart_i;
    logic           exitWarp_i;
    logic [NWL-1:0] exitWarpId_i;
    logic           branchIssue_i;
    logic [NWL-1:0] branchIssueWarp_i;
    logic           branchResolved_i;
    logic [NWL-1:0] branchResolvedWarp_i;
    logic [PCW-1:0] topPC_i;
    logic [PCW-1:0] topRPC_i;
    logic [CW-1:0]  topActiveMask_i;
    logic           pushInStack_stall_i;
    logic [NWL-1:0] issuedWarp_o;
    logic           reconv_o;
    logic           fetchValid_o;
    logic [PCW-1:0] fetchPC_o;
    logic [CW-1:0]  fetchMask_o;
    logic [NWL-1:0] fetchWarp_o;
    logic           fetchReady_i;
    logic [NW-1:0]  warpDone_o;

    always #5 clk = ~clk;

    warp_fetch_sched #(
        .NUM_WARP(NW), .NUM_WARP_LOG(NWL), .SIZE_PC(PCW), .SIZE_CORE(CW)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .warpStart_i(warpStart_i),
        .exitWarp_i(exitWarp_i), .exitWarpId_i(exitWarpId_i),
        .branchIssue_i(branchIssue_i), .branchIssueWarp_i(branchIssueWarp_i),
        .branchResolved_i(branchResolved_i), .branchResolvedWarp_i(branchResolvedWarp_i),
        .topPC_i(topPC_i), .topRPC_i(topRPC_i), .topActiveMask_i(topActiveMask_i),
        .pushInStack_stall_i(pushInStack_stall_i),
        .issuedWarp_o(issuedWarp_o), .reconv_o(reconv_o),
        .fetchValid_o(fetchValid_o), .fetchPC_o(fetchPC_o), .fetchMask_o(fetchMask_o),
        .fetchWarp_o(fetchWarp_o), .fetchReady_i(fetchReady_i), .warpDone_o(warpDone_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             m_st[NW];
    logic [PCW-1:0] m_pc[NW];
    logic [CW-1:0]  m_mask[NW];
    int             m_rr;
    bit             m_fv;
    logic [PCW-1:0] m_fpc;
    logic [CW-1:0]  m_fmask;
    int             m_fw;
    logic [NW-1:0]  m_done;

    int log_w[$];
    int log_pc[$];
    bit obs_rc2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_st[w]   = S_IDLE;
            m_pc[w]   = '0;
            m_mask[w] = '0;
        end
        m_rr    = NW - 1;
        m_fv    = 1'b0;
        m_fpc   = '0;
        m_fmask = '0;
        m_fw    = 0;
        m_done  = '0;
    endtask

    function automatic int pick_ready();
`ifdef WARP_SCHED_GTO_EN
        if (m_st[m_rr] == S_READY) return m_rr;
        for (int w = 0; w < NW; w++) if (m_st[w] == S_READY) return w;
        return -1;
`else
        for (int k = 1; k <= NW; k++) begin
            if (m_st[(m_rr + k) % NW] == S_READY) return (m_rr + k) % NW;
        end
        return -1;
`endif
    endfunction

    // One clock cycle: check combinational outputs, advance model at the edge, check registered outputs.
    task automatic tick();
        int rl, rd, exp_iw;
        bit slot, rc, ld;
        int ns[NW];
        #1;
        slot = !stall_i && !pushInStack_stall_i && (!m_fv || fetchReady_i);
        rl = -1;
        for (int w = NW - 1; w >= 0; w--) if (m_st[w] == S_RELOAD) rl = w;
        rd = pick_ready();
        exp_iw = (rl >= 0) ? rl : ((rd >= 0) ? rd : m_rr);
        rc = slot && (rl < 0) && (rd >= 0) && (m_pc[rd] == topRPC_i);
        chk("issuedWarp", 64'(issuedWarp_o), 64'(exp_iw));
        chk("reconv", 64'(reconv_o), 64'(rc));
        if (reconv_o === 1'b1 && issuedWarp_o === 2'd2) obs_rc2 = 1'b1;
        if (!reset && !stall_i && fetchValid_o === 1'b1 && fetchReady_i) begin
            log_w.push_back(int'(fetchWarp_o));
            log_pc.push_back(int'(fetchPC_o));
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!stall_i) begin
            for (int w = 0; w < NW; w++) ns[w] = m_st[w];
            ld = 1'b0;
            if (slot && rl >= 0) begin
                ns[rl]     = S_READY;
                m_pc[rl]   = topPC_i;
                m_mask[rl] = topActiveMask_i;
            end else if (slot && rd >= 0) begin
                m_rr = rd;
                if (rc) begin
                    ns[rd] = S_RELOAD;
                end else begin
                    ld       = 1'b1;
                    m_fv     = 1'b1;
                    m_fpc    = m_pc[rd];
                    m_fmask  = m_mask[rd];
                    m_fw     = rd;
                    m_pc[rd] = m_pc[rd] + 1'b1;
                end
            end
            if (!ld && fetchReady_i) m_fv = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (exitWarp_i && int'(exitWarpId_i) == w) ns[w] = S_DONE;
                else if (branchResolved_i && int'(branchResolvedWarp_i) == w && m_st[w] == S_BLOCKED) ns[w] = S_RELOAD;
                else if (branchIssue_i && int'(branchIssueWarp_i) == w && m_st[w] == S_READY) ns[w] = S_BLOCKED;
                else if (warpStart_i[w] && m_st[w] == S_IDLE) ns[w] = S_RELOAD;
            end
            for (int w = 0; w < NW; w++) begin
                m_st[w]   = ns[w];
                m_done[w] = (ns[w] == S_DONE);
            end
        end
        #1;
        chk("fetchValid", 64'(fetchValid_o), 64'(m_fv));
        chk("fetchPC", 64'(fetchPC_o), 64'(m_fpc));
        chk("fetchMask", 64'(fetchMask_o), 64'(m_fmask));
        chk("fetchWarp", 64'(fetchWarp_o), 64'(m_fw));
        chk("warpDone", 64'(warpDone_o), 64'(m_done));
        warpStart_i      = '0;
        exitWarp_i       = 1'b0;
        branchIssue_i    = 1'b0;
        branchResolved_i = 1'b0;
        reset            = 1'b0;
    endtask

    initial begin
        logic [PCW-1:0] held_pc;
        logic [NWL-1:0] held_w;
        int first_w1_pc, cnt3, cnt_not0;
        int exp_w[5];
        int exp_pc[5];

        reset = 1'b1; stall_i = 1'b0; warpStart_i = '0;
        exitWarp_i = 1'b0; exitWarpId_i = '0;
        branchIssue_i = 1'b0; branchIssueWarp_i = '0;
        branchResolved_i = 1'b0; branchResolvedWarp_i = '0;
        topPC_i = 8'h10; topRPC_i = 8'hFF; topActiveMask_i = 4'hF;
        pushInStack_stall_i = 1'b0; fetchReady_i = 1'b1;
        obs_rc2 = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetchValid", 64'(fetchValid_o), 64'd0);
        chk("rst_fetchPC", 64'(fetchPC_o), 64'd0);
        chk("rst_fetchMask", 64'(fetchMask_o), 64'd0);
        chk("rst_fetchWarp", 64'(fetchWarp_o), 64'd0);
        chk("rst_warpDone", 64'(warpDone_o), 64'd0);
        chk("rst_issuedWarp", 64'(issuedWarp_o), 64'd3);
        chk("rst_reconv", 64'(reconv_o), 64'd0);
        reset = 1'b0;

        // Launch all warps from PC 0x10
        log_w.delete(); log_pc.delete();
        warpStart_i = 4'b1111;
        tick();
        repeat (11) tick();
`ifdef WARP_SCHED_GTO_EN
        exp_w  = '{3, 3, 3, 3, 3};
        exp_pc = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
`else
        exp_w  = '{0, 1, 2, 3, 0};
        exp_pc = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h11};
`endif
        chk("launch_log_len", 64'(log_w.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < log_w.size()) begin
                chk("launch_warp", 64'(log_w[i]), 64'(exp_w[i]));
                chk("launch_pc", 64'(log_pc[i]), 64'(exp_pc[i]));
            end
        end

        // Branch on warp 1, resolved three cycles later to 0x40
        branchIssue_i = 1'b1; branchIssueWarp_i = 2'd1;
        tick();
        tick();
        tick();
        branchResolved_i = 1'b1; branchResolvedWarp_i = 2'd1; topPC_i = 8'h40;
        tick();
        log_w.delete(); log_pc.delete();
        repeat (8) tick();
`ifndef WARP_SCHED_GTO_EN
        first_w1_pc = -1;
        for (int i = log_w.size() - 1; i >= 0; i--) if (log_w[i] == 1) first_w1_pc = log_pc[i];
        chk("branch_w1_pc", 64'(first_w1_pc), 64'h40);

        // Reconvergence on warp 2
        topRPC_i = m_pc[2];
        obs_rc2 = 1'b0;
        for (int i = 0; i < 10 && !obs_rc2; i++) tick();
        chk("reconv_w2", 64'(obs_rc2), 64'd1);
        topRPC_i = 8'hFF;
        repeat (3) tick();
`endif

        // Back-pressure: outputs hold while fetchReady_i is low
        held_pc = fetchPC_o;
        held_w  = fetchWarp_o;
        fetchReady_i = 1'b0;
        repeat (5) tick();
        chk("hold_valid", 64'(fetchValid_o), 64'd1);
        chk("hold_pc", 64'(fetchPC_o), 64'(held_pc));
        chk("hold_warp", 64'(fetchWarp_o), 64'(held_w));
        fetchReady_i = 1'b1;
        pushInStack_stall_i = 1'b1;
        repeat (3) tick();
        pushInStack_stall_i = 1'b0;
        tick();

        // Exit and resolve warp 3 together
        exitWarp_i = 1'b1; exitWarpId_i = 2'd3;
        branchResolved_i = 1'b1; branchResolvedWarp_i = 2'd3;
        tick();
        chk("exit_done3", 64'(warpDone_o[3]), 64'd1);
        tick();
        log_w.delete(); log_pc.delete();
        repeat (12) tick();
        cnt3 = 0; cnt_not0 = 0;
        foreach (log_w[i]) begin
            if (log_w[i] == 3) cnt3++;
            if (log_w[i] != 0) cnt_not0++;
        end
        chk("exit_no_w3", 64'(cnt3), 64'd0);
`ifdef WARP_SCHED_GTO_EN
        chk("gto_only_w0", 64'(cnt_not0), 64'd0);
        chk("gto_w0_busy", 64'(log_w.size() > 0), 64'd1);
`endif

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b1; stall_i = 1'b1; fetchReady_i = 1'b0;
            end else begin
                stall_i             = ($urandom_range(0, 9) == 0);
                pushInStack_stall_i = ($urandom_range(0, 9) == 0);
                fetchReady_i        = ($urandom_range(0, 9) < 7);
                warpStart_i         = ($urandom_range(0, 9) == 0) ? NW'($urandom) : '0;
                exitWarp_i          = ($urandom_range(0, 39) == 0);
                exitWarpId_i        = NWL'($urandom);
                branchIssue_i       = ($urandom_range(0, 6) == 0);
                branchIssueWarp_i   = NWL'($urandom);
                branchResolved_i    = ($urandom_range(0, 4) == 0);
                branchResolvedWarp_i = NWL'($urandom);
                topPC_i             = PCW'($urandom);
                topActiveMask_i     = CW'($urandom);
                topRPC_i            = ($urandom_range(0, 3) == 0) ? m_pc[$urandom_range(0, NW - 1)] : PCW'($urandom);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
